// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the TT query framer
//
// Purpose: node width, FSM state encoding, packed edge type and the cost
// value TT reports for an unreachable target.
// Ports: none (package).
package tt_pkg;

  localparam int NODE_W = 4;

  // TT reports cost 0 when the target cannot be reached
  localparam logic [NODE_W-1:0] COST_UNREACH = '0;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DROP     = 2'd1,
    BURST    = 2'd2,
    WAIT_RES = 2'd3
  } state_e;

  // One buffer entry: header {start,target} or edge {endpoint A,endpoint B}
  typedef struct packed {
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dst;
  } edge_t;

endpackage

// File: rtl/tt_frame_buf.sv
// rtl/tt_frame_buf.sv - DEPTH x 8-bit frame storage, sync write, comb read
//
// Purpose: holds one query frame (header + edges) while it is collected.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  entry to write
//   i_rd_addr  read address
//   o_rd_data  entry at i_rd_addr, combinational
module tt_frame_buf
  import tt_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  edge_t         i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output edge_t         o_rd_data
);

  edge_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/tt_query_framer.sv
// rtl/tt_query_framer.sv - buffers a query frame and replays it to TT as one burst
//
// Purpose: collects a header+edges frame from a bursty valid/ready stream,
// replays it to TT as a gap-free in_valid burst, then forwards TT's cost as
// a one-cycle result pulse. Frames larger than DEPTH entries are dropped
// with a frame_err pulse.
// Build option: TT_QF_SELF_LOOP_FILTER_EN - when defined, edge beats with
// equal endpoints are accepted but not buffered.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_up_valid/o_up_ready     upstream beat handshake
//   i_up_src/i_up_dst         header {start,target} or edge {A,B}
//   i_up_last                 final beat of a frame
//   o_tt_in_valid             TT in_valid
//   o_tt_source/o_tt_destination  TT source/destination
//   i_tt_out_valid/i_tt_cost  TT result
//   o_res_valid/o_res_cost    result pulse / held cost
//   o_frame_err               frame dropped on overflow (pulse)
//   o_busy                    high whenever not collecting
module tt_query_framer
  import tt_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [NODE_W-1:0] i_up_src,
  input  logic [NODE_W-1:0] i_up_dst,
  input  logic              i_up_last,
  output logic              o_tt_in_valid,
  output logic [NODE_W-1:0] o_tt_source,
  output logic [NODE_W-1:0] o_tt_destination,
  input  logic              i_tt_out_valid,
  input  logic [NODE_W-1:0] i_tt_cost,
  output logic              o_res_valid,
  output logic [NODE_W-1:0] o_res_cost,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_tt_in_valid;
  edge_t             r_tt_edge;
  logic              r_res_valid;
  logic [NODE_W-1:0] r_res_cost;
  logic              r_frame_err;

  logic              w_up_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_skip;
  logic              w_overflow;
  logic              w_wr_en;
  logic              w_burst_done;
  edge_t             w_wr_data;
  edge_t             w_rd_data;

  assign w_accept  = i_up_valid && w_up_ready;
  assign w_wr_data = '{src: i_up_src, dst: i_up_dst};

`ifdef TT_QF_SELF_LOOP_FILTER_EN
  // count==0 marks the header beat, which is never filtered
  assign w_skip = (r_count != '0) && (i_up_src == i_up_dst);
`else
  assign w_skip = 1'b0;
`endif

  // A filtered beat never needs storage, so it cannot overflow the buffer
  assign w_overflow   = (r_count == CNT_FULL) && !w_skip;
  assign w_wr_en      = (r_state == COLLECT) && w_accept && !w_skip && !w_overflow;
  // rd_ptr is the entry being sent this cycle; the burst ends once the last entry goes out
  assign w_burst_done = (({1'b0, r_rd_ptr} + CNT_ONE) == r_count);

  tt_frame_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (w_overflow) begin
            w_state_nxt = i_up_last ? COLLECT : DROP;
          end else if (i_up_last) begin
            w_state_nxt = BURST;
          end
        end
      end
      DROP: begin
        if (w_accept && i_up_last) begin
          w_state_nxt = COLLECT;
        end
      end
      BURST: begin
        if (w_burst_done) begin
          w_state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (i_tt_out_valid) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_up_ready = (r_state == COLLECT) || (r_state == DROP);
    w_busy     = (r_state != COLLECT);
  end

  // Pointers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_tt_in_valid <= 1'b0;
      r_tt_edge     <= '0;
      r_res_valid   <= 1'b0;
      r_res_cost    <= COST_UNREACH;
      r_frame_err   <= 1'b0;
    end else begin
      r_tt_in_valid <= 1'b0;
      r_res_valid   <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_count  <= r_count + CNT_ONE;
          end
          if (w_accept && w_overflow && i_up_last) begin
            r_frame_err <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end else if (w_accept && !w_overflow && i_up_last) begin
            r_rd_ptr <= '0;
          end
        end
        DROP: begin
          if (w_accept && i_up_last) begin
            r_frame_err <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end
        end
        BURST: begin
          r_tt_in_valid <= 1'b1;
          r_tt_edge     <= w_rd_data;
          r_rd_ptr      <= r_rd_ptr + PTR_ONE;
        end
        WAIT_RES: begin
          if (i_tt_out_valid) begin
            r_res_cost  <= i_tt_cost;
            r_res_valid <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_up_ready       = w_up_ready;
  assign o_busy           = w_busy;
  assign o_tt_in_valid    = r_tt_in_valid;
  assign o_tt_source      = r_tt_edge.src;
  assign o_tt_destination = r_tt_edge.dst;
  assign o_res_valid      = r_res_valid;
  assign o_res_cost       = r_res_cost;
  assign o_frame_err      = r_frame_err;

endmodule

// File: tb/tb_tt_query_framer.sv
// tb/tb_tt_query_framer.sv - self-checking bench for tt_query_framer
module tb_tt_query_framer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_src;
  logic [3:0] up_dst;
  logic       up_last;
  logic       tt_in_valid;
  logic [3:0] tt_source;
  logic [3:0] tt_destination;
  logic       tt_out_valid;
  logic [3:0] tt_cost;
  logic       res_valid;
  logic [3:0] res_cost;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  tt_query_framer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_up_valid       (up_valid),
    .o_up_ready       (up_ready),
    .i_up_src         (up_src),
    .i_up_dst         (up_dst),
    .i_up_last        (up_last),
    .o_tt_in_valid    (tt_in_valid),
    .o_tt_source      (tt_source),
    .o_tt_destination (tt_destination),
    .i_tt_out_valid   (tt_out_valid),
    .i_tt_cost        (tt_cost),
    .o_res_valid      (res_valid),
    .o_res_cost       (res_cost),
    .o_frame_err      (frame_err),
    .o_busy           (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Hop distance between header endpoints over an undirected edge list; 0 if unreachable
  function automatic int bfs_cost(input logic [7:0] e [64], input int n);
    int d [16];
    int s, t, a, b;
    for (int i = 0; i < 16; i++) d[i] = -1;
    s = int'(e[0][7:4]);
    t = int'(e[0][3:0]);
    d[s] = 0;
    for (int r = 0; r < 16; r++) begin
      for (int i = 1; i < n; i++) begin
        a = int'(e[i][7:4]);
        b = int'(e[i][3:0]);
        if (d[a] >= 0 && (d[b] < 0 || d[b] > d[a] + 1)) d[b] = d[a] + 1;
        if (d[b] >= 0 && (d[a] < 0 || d[a] > d[b] + 1)) d[a] = d[b] + 1;
      end
    end
    return (d[t] < 0) ? 0 : d[t];
  endfunction

  // Expectations produced by the frame model
  logic [7:0] exp_pairs [$];
  int         exp_len   [$];
  int         exp_cost  [$];
  int         exp_err   = 0;

  int res_seen      = 0;
  int err_seen      = 0;
  int last_res_cost = 0;
  int last_burst    = 0;
  int run           = 0;

  // Compare process: every falling edge, outputs are stable
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (tt_in_valid) begin
          run++;
          if (exp_pairs.size() == 0) chk("tt_in_valid_unexpected", int'(tt_in_valid), 0);
          else chk("tt_pair", int'({tt_source, tt_destination}), int'(exp_pairs.pop_front()));
        end else if (run > 0) begin
          last_burst = run;
          if (exp_len.size() == 0) chk("burst_unexpected", run, 0);
          else chk("burst_len", run, exp_len.pop_front());
          run = 0;
        end
        if (res_valid) begin
          res_seen++;
          last_res_cost = int'(res_cost);
          if (exp_cost.size() == 0) chk("res_valid_unexpected", int'(res_valid), 0);
          else chk("res_cost", int'(res_cost), exp_cost.pop_front());
        end
        if (frame_err) begin
          err_seen++;
          chk("frame_err_expected", int'(exp_err > 0), 1);
          if (exp_err > 0) exp_err--;
        end
      end
    end
  end

  // TT engine stand-in: answers 3 cycles after a frame's in_valid run ends
  initial begin
    logic [7:0] tbuf [64];
    int         tn;
    int         pend;
    logic [3:0] pc;
    tn = 0; pend = 0; pc = '0;
    tt_out_valid = 1'b0;
    tt_cost      = '0;
    forever begin
      @(posedge clk);
      #2;
      tt_out_valid = 1'b0;
      if (rst) begin
        tn   = 0;
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            tt_out_valid = 1'b1;
            tt_cost      = pc;
          end
        end
        if (tt_in_valid) begin
          tbuf[tn] = {tt_source, tt_destination};
          tn++;
        end else if (tn > 0) begin
          pc   = 4'(bfs_cost(tbuf, tn));
          pend = 3;
          tn   = 0;
        end
      end
    end
  end

  // Beats listed most-significant byte first, byte = {src,dst}
  task automatic send(input int n, input logic [63:0] v, input bit bursty);
    logic [7:0] kept [64];
    logic [7:0] b;
    int         k;
    int         t;
    k = 0;
    for (int i = 0; i < n; i++) begin
      b = v[63-8*i -: 8];
`ifdef TT_QF_SELF_LOOP_FILTER_EN
      if (!(i > 0 && b[7:4] == b[3:0])) begin
        kept[k] = b;
        k++;
      end
`else
      kept[k] = b;
      k++;
`endif
    end
    if (k > DEPTH) begin
      exp_err++;
    end else begin
      for (int i = 0; i < k; i++) exp_pairs.push_back(kept[i]);
      exp_len.push_back(k);
      exp_cost.push_back(bfs_cost(kept, k));
    end
    for (int i = 0; i < n; i++) begin
      b        = v[63-8*i -: 8];
      up_valid = 1'b1;
      up_src   = b[7:4];
      up_dst   = b[3:0];
      up_last  = (i == n - 1);
      t = 0;
      while (!up_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (!up_ready) chk("up_ready_timeout", int'(up_ready), 1);
      @(posedge clk); #1;
      up_valid = 1'b0;
      up_last  = 1'b0;
      up_src   = 4'hA;
      up_dst   = 4'h5;
      if (bursty && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_res(input string name, input int r0, input int cost, input int blen);
    int t;
    t = 0;
    while (res_seen == r0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_res_seen"}, int'(res_seen > r0), 1);
    chk({name, "_cost"}, last_res_cost, cost);
    chk({name, "_burst"}, last_burst, blen);
    chk({name, "_ready_after"}, int'(up_ready), 1);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_up_ready"}, int'(up_ready), 1);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_tt_in_valid"}, int'(tt_in_valid), 0);
    chk({name, "_tt_source"}, int'(tt_source), 0);
    chk({name, "_tt_destination"}, int'(tt_destination), 0);
    chk({name, "_res_valid"}, int'(res_valid), 0);
    chk({name, "_res_cost"}, int'(res_cost), 0);
    chk({name, "_frame_err"}, int'(frame_err), 0);
  endtask

  localparam logic [63:0] CHAIN = 64'h0301122300000000;

  initial begin
    int r0;
    int e0;
    int t;
    rst = 1'b1; up_valid = 1'b0; up_src = '0; up_dst = '0; up_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Chain query with latency and busy checks
    r0 = res_seen;
    send(4, CHAIN, 1'b0);
    chk("chain_ready_in_burst", int'(up_ready), 0);
    chk("chain_busy_in_burst", int'(busy), 1);
    chk("chain_lat_cycle1", int'(tt_in_valid), 0);
    @(posedge clk); #1;
    chk("chain_lat_cycle2", int'(tt_in_valid), 1);
    chk("chain_first_pair", int'({tt_source, tt_destination}), 8'h03);
    wait_res("chain", r0, 3, 4);

    // Bursty upstream
    r0 = res_seen;
    send(4, CHAIN, 1'b1);
    wait_res("bursty", r0, 3, 4);

    // Unreachable target
    r0 = res_seen;
    send(2, 64'h5956000000000000, 1'b0);
    wait_res("unreach", r0, 0, 2);

    // Zero-edge frame
    r0 = res_seen;
    send(1, 64'h2700000000000000, 1'b0);
    wait_res("zero_edge", r0, 0, 1);

    // Overflow: 6 beats into a 4-entry buffer
    e0 = err_seen;
    send(6, 64'h0101122334450000, 1'b0);
    chk("ovf6_err_pulse", int'(frame_err), 1);
    chk("ovf6_ready", int'(up_ready), 1);
    @(posedge clk); #1;
    chk("ovf6_err_one_cycle", int'(frame_err), 0);
    chk("ovf6_err_seen", err_seen - e0, 1);

    // Overflow where the beat that hits the full buffer is the last one
    e0 = err_seen;
    send(5, 64'h0101122334000000, 1'b0);
    chk("ovf5_err_pulse", int'(frame_err), 1);
    chk("ovf5_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("ovf5_err_seen", err_seen - e0, 1);

    r0 = res_seen;
    send(4, CHAIN, 1'b0);
    wait_res("after_ovf", r0, 3, 4);

    // Reset in the second burst cycle
    send(4, CHAIN, 1'b0);
    @(posedge clk); #1;
    chk("rstb_burst1", int'(tt_in_valid), 1);
    @(posedge clk); #1;
    chk("rstb_burst2", int'(tt_in_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("rstb");
    exp_pairs.delete();
    exp_len.delete();
    exp_cost.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    r0 = res_seen;
    send(4, CHAIN, 1'b0);
    wait_res("after_rst", r0, 3, 4);

    // Self-loop edge
    r0 = res_seen;
    send(3, 64'h1211120000000000, 1'b0);
`ifdef TT_QF_SELF_LOOP_FILTER_EN
    wait_res("selfloop", r0, 1, 2);
`else
    wait_res("selfloop", r0, 1, 3);
`endif

    t = 0;
    while (t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("leftover_pairs", exp_pairs.size(), 0);
    chk("leftover_costs", exp_cost.size(), 0);
    chk("leftover_errs", exp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_query_framer.md
Name: tt_query_framer

Overview:
- Upstream front-end for the TT shortest-path engine (16-node undirected graph, BFS hop cost).
- Accepts a query frame over a valid/ready byte stream; the stream may have bubbles.
- Buffers the whole frame, then replays it to TT as one gap-free in_valid burst: header first, then edges.
- Waits for TT's out_valid/cost and forwards the result downstream as a one-cycle pulse.

Parameters:
- DEPTH, 32: buffer entries. One entry holds the header, the rest hold edges, so at most DEPTH-1 edges per frame.
- AW, 5: buffer address width, equal to log2(DEPTH).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- up_valid  in  1  upstream beat valid.
- up_ready  out  1  block can accept a beat.
- up_src  in  4  header: start node; edge beat: edge endpoint A.
- up_dst  in  4  header: target node; edge beat: edge endpoint B.
- up_last  in  1  marks the final beat of a frame. Allowed on the header beat, meaning a frame with zero edges.
- tt_in_valid  out  1  drives TT in_valid.
- tt_source  out  4  drives TT source.
- tt_destination  out  4  drives TT destination.
- tt_out_valid  in  1  TT out_valid.
- tt_cost  in  4  TT cost; 0 means unreachable.
- res_valid  out  1  one-cycle result pulse.
- res_cost  out  4  result cost, held until the next res_valid.
- frame_err  out  1  one-cycle pulse: frame was dropped because of overflow.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset values: up_ready=1, tt_in_valid=0, tt_source=0, tt_destination=0, res_valid=0, res_cost=0, frame_err=0, busy=0. Write pointer, read pointer and count are 0. State is COLLECT.
- All outputs except up_ready and busy are registered. up_ready and busy are decoded from the state only, never from up_valid.
- A beat is accepted when up_valid && up_ready. The first accepted beat of a frame is the header.

State COLLECT:
- up_ready=1.
- Each accepted beat is written to mem[wr_ptr]; wr_ptr and count are incremented.
- Accepted beat with up_last and count < DEPTH: go to BURST and set rd_ptr=0.
- Accepted beat while count==DEPTH (buffer full): go to DROP. If that beat also carries up_last, go straight back to COLLECT with pointers cleared instead, and still pulse frame_err.

State DROP:
- up_ready=1; accepted beats are discarded.
- On the beat carrying up_last: pulse frame_err the next cycle, clear the pointers, go to COLLECT.
- No TT traffic is generated for a dropped frame.

State BURST:
- up_ready=0.
- Each cycle: tt_in_valid<=1, {tt_source,tt_destination}<=mem[rd_ptr], rd_ptr++.
- When rd_ptr reaches count, go to WAIT_RES; tt_in_valid is 0 on the following cycle.
- Result: tt_in_valid is high for exactly count consecutive cycles. The first high cycle is 2 cycles after the up_last handshake. There are no gaps, because TT ends a frame on the first low cycle.

State WAIT_RES:
- up_ready=0, tt_in_valid=0.
- On tt_out_valid: res_cost<=tt_cost, res_valid<=1 for one cycle, pointers cleared, go to COLLECT.
- Combined with WAIT_RES, this gives at least one idle in_valid cycle between TT frames.
- There is no timeout. tt_out_valid in any other state is ignored.

Other rules:
- Arithmetic: count is AW+1 bits; pointers are AW bits and never wrap within one frame.
- Reset in any state, including mid-BURST, returns to the reset values on the next edge. tt_in_valid drops immediately. The partial frame is lost; the system reset also resets TT.
- up_valid with up_ready=0 is held off by upstream; the block requires no data stability while ready is low.

Optional Feature:
- Macro: TT_QF_SELF_LOOP_FILTER_EN.
- Defined: in COLLECT, an edge beat (not the header) with up_src==up_dst is accepted but not written, and count is not incremented. If that beat carries up_last, the frame still closes normally.
- Not defined: self-loops are buffered and forwarded unchanged.

Decomposition:
- Package tt_pkg holds:
  - NODE_W=4;
  - the state encoding COLLECT/DROP/BURST/WAIT_RES;
  - the packed edge type {src,dst} (8 bits);
  - COST_UNREACH=0.
- One sub-module, tt_frame_buf: simple dual-port storage of DEPTH x 8 bits, with synchronous write and combinational read.
- The FSM and pointers stay in the top module.

Test Plan:
- Chain query: header (0,3), edges (0,1),(1,2),(2,3) with up_last on the last edge, against a TT model. Expect tt_in_valid high 4 consecutive cycles with pairs (0,3),(0,1),(1,2),(2,3), then res_valid with res_cost=3.
- Bursty upstream: same frame with up_valid low on alternate cycles. Expect an identical contiguous 4-cycle burst and res_cost=3.
- Unreachable: header (5,9), edges (5,6) last. Expect res_cost=0 and a single res_valid pulse.
- Zero-edge frame: header (2,7) with up_last. Expect a 1-cycle tt_in_valid burst and res_cost=0.
- Overflow with DEPTH=4: a 6-beat frame. Expect a frame_err pulse after the last beat, tt_in_valid never high, and up_ready returning to 1. The next valid frame then runs normally.
- Reset mid-BURST: assert rst in the 2nd burst cycle. Expect tt_in_valid=0 the next cycle, all outputs at reset values, and a subsequent frame processed correctly.
- With TT_QF_SELF_LOOP_FILTER_EN: edges (1,1),(1,2) for header (1,2). Expect a 2-cycle burst (1,2),(1,2) and res_cost=1.
